// File: rtl/garbled_and_eval_pkg.sv
// Shared widths, state encoding and gate-type constants for the garbled-gate evaluator
// and the top-level controller that drives it.
package garbled_and_eval_pkg;

    localparam int unsigned LABEL_W = 128;
    localparam int unsigned N_CTXT  = 4;
    localparam int unsigned IDX_W   = $clog2(N_CTXT);

    // Gate-type codes; the top-level FSM must use the same values
    localparam logic [1:0] AND_GATE = 2'd0;
    localparam logic [1:0] XOR_GATE = 2'd1;
    localparam logic [1:0] BUF_GATE = 2'd2;

    typedef logic [LABEL_W-1:0] label_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AES_WAIT  = 2'd1,
        CTXT_WAIT = 2'd2
    } eval_state_e;

    // One ciphertext row as streamed out of the gate deserializer
    typedef struct packed {
        idx_t   idx;
        label_t data;
    } ctxt_row_t;

endpackage

// File: rtl/garbled_and_eval_if.sv
// Signal bundle between the evaluator, the top-level controller/deserializer and the aes core.
interface garbled_and_eval_if;
    import garbled_and_eval_pkg::*;

    logic   start;
    label_t label_in;
    idx_t   ctxt_point;
    label_t ctxt_in;
    idx_t   ctxt_idx;
    logic   ctxt_strobe;
    logic   gate_id_strobe;
    logic   aes_start;
    label_t aes_state_init;
    logic   aes_done;
    label_t aes_out;
    label_t label_out;
    logic   done;
    logic   busy;
    logic   error;
    logic   clear_error;

    modport master (
        output start, label_in, ctxt_point, ctxt_in, ctxt_idx, ctxt_strobe,
               gate_id_strobe, aes_done, aes_out, clear_error,
        input  aes_start, aes_state_init, label_out, done, busy, error
    );

    modport slave (
        input  start, label_in, ctxt_point, ctxt_in, ctxt_idx, ctxt_strobe,
               gate_id_strobe, aes_done, aes_out, clear_error,
        output aes_start, aes_state_init, label_out, done, busy, error
    );

endinterface

// File: rtl/garbled_and_eval_ctxt_row_buffer.sv
// Per-gate ciphertext row store: write port, valid bits cleared at end of gate record,
// and a read mux that forwards a same-cycle write to the selected row.
module garbled_and_eval_ctxt_row_buffer
    import garbled_and_eval_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  ctxt_row_t wr_row,
    input  logic      clr,
    input  idx_t      rd_idx,
    output logic      rd_hit_c,
    output label_t    rd_data_c,
    output logic      overwrite_c
);

    label_t            rows [N_CTXT];
    logic [N_CTXT-1:0] valid;

    // A write in the same cycle as a clear keeps its entry valid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clr) begin
                valid <= '0;
            end
            if (wr_en) begin
                valid[wr_row.idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_row.idx] <= wr_row.data;
        end
    end

    always_comb begin
        rd_hit_c    = valid[rd_idx];
        rd_data_c   = rows[rd_idx];
        overwrite_c = wr_en && valid[wr_row.idx];
        if (wr_en && (wr_row.idx == rd_idx)) begin
            rd_hit_c  = 1'b1;
            rd_data_c = wr_row.data;
        end
    end

endmodule

// File: rtl/garbled_and_eval.sv
// Garbled AND gate evaluation: encrypt the input label, then XOR the result with the
// ciphertext row chosen by the point-and-permute bits to produce the output label.
module garbled_and_eval
    import garbled_and_eval_pkg::*;
(
    input logic               clk,
    input logic               rst,
    garbled_and_eval_if.slave bus
);

    eval_state_e state;
    idx_t        point;
    label_t      aes_lat;
    label_t      aes_state_init_q;
    label_t      label_out_q;
    logic        aes_start_q;
    logic        done_q;
    logic        busy_q;
    logic        error_q;

    logic      rd_hit_c;
    label_t    rd_data_c;
    logic      overwrite_c;
    ctxt_row_t wr_row_c;
    logic      row_match_c;
    logic      err_set_c;

    assign wr_row_c    = '{idx: bus.ctxt_idx, data: bus.ctxt_in};
    assign row_match_c = bus.ctxt_strobe && (bus.ctxt_idx == point);
    assign err_set_c   = overwrite_c
                       || (bus.start          && (state != IDLE))
                       || (bus.gate_id_strobe && (state != IDLE));

    garbled_and_eval_ctxt_row_buffer u_row_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.ctxt_strobe),
        .wr_row      (wr_row_c),
        .clr         (bus.gate_id_strobe),
        .rd_idx      (point),
        .rd_hit_c    (rd_hit_c),
        .rd_data_c   (rd_data_c),
        .overwrite_c (overwrite_c)
    );

    // Evaluation FSM; aes_done outside AES_WAIT is silently dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            point            <= '0;
            aes_lat          <= '0;
            aes_state_init_q <= '0;
            label_out_q      <= '0;
            aes_start_q      <= 1'b0;
            done_q           <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            aes_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        aes_state_init_q <= bus.label_in;
                        point            <= bus.ctxt_point;
                        aes_start_q      <= 1'b1;
                        busy_q           <= 1'b1;
                        state            <= AES_WAIT;
                    end
                end
                AES_WAIT: begin
                    if (bus.aes_done) begin
                        if (rd_hit_c) begin
                            label_out_q <= bus.aes_out ^ rd_data_c;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            aes_lat <= bus.aes_out;
                            state   <= CTXT_WAIT;
                        end
                    end
                end
                CTXT_WAIT: begin
                    if (row_match_c) begin
                        label_out_q <= aes_lat ^ bus.ctxt_in;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error; a new error event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (err_set_c) begin
            error_q <= 1'b1;
        end else if (bus.clear_error) begin
            error_q <= 1'b0;
        end
    end

    assign bus.aes_start      = aes_start_q;
    assign bus.aes_state_init = aes_state_init_q;
    assign bus.label_out      = label_out_q;
    assign bus.done           = done_q;
    assign bus.busy           = busy_q;
    assign bus.error          = error_q;

endmodule

// File: tb/tb_garbled_and_eval.sv
// Directed bench for garbled_and_eval: hand-computed labels, bypass, error and reset cases.
module tb_garbled_and_eval;
    import garbled_and_eval_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    garbled_and_eval_if bus ();

    garbled_and_eval dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic label_t fill(input logic [7:0] b);
        return {(LABEL_W/8){b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input label_t got, input label_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put_row(input int idx, input logic [7:0] b);
        bus.ctxt_strobe = 1'b1;
        bus.ctxt_idx    = idx_t'(idx);
        bus.ctxt_in     = fill(b);
        tick();
        bus.ctxt_strobe = 1'b0;
    endtask

    task automatic end_gate();
        bus.gate_id_strobe = 1'b1;
        tick();
        bus.gate_id_strobe = 1'b0;
    endtask

    task automatic do_start(input int pt, input logic [7:0] b);
        bus.start      = 1'b1;
        bus.ctxt_point = idx_t'(pt);
        bus.label_in   = fill(b);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_aes(input logic [7:0] b);
        bus.aes_done = 1'b1;
        bus.aes_out  = fill(b);
        tick();
        bus.aes_done = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.start          = 1'b0;
        bus.label_in       = '0;
        bus.ctxt_point     = '0;
        bus.ctxt_in        = '0;
        bus.ctxt_idx       = '0;
        bus.ctxt_strobe    = 1'b0;
        bus.gate_id_strobe = 1'b0;
        bus.aes_done       = 1'b0;
        bus.aes_out        = '0;
        bus.clear_error    = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        check("rst_aes_start", label_t'(bus.aes_start), '0);
        check("rst_done", label_t'(bus.done), '0);
        check("rst_busy", label_t'(bus.busy), '0);
        check("rst_error", label_t'(bus.error), '0);
        check("rst_label_out", bus.label_out, '0);
        check("rst_state_init", bus.aes_state_init, '0);
        rst = 1'b0;
        tick();

        // Rows preloaded, point=2
        put_row(0, 8'h11);
        put_row(1, 8'h22);
        put_row(2, 8'h33);
        put_row(3, 8'h44);
        do_start(2, 8'hA5);
        check("t1_aes_start", label_t'(bus.aes_start), label_t'(1));
        check("t1_state_init", bus.aes_state_init, fill(8'hA5));
        check("t1_busy", label_t'(bus.busy), label_t'(1));
        tick();
        check("t1_aes_start_once", label_t'(bus.aes_start), '0);
        do_aes(8'hF0);
        check("t1_done", label_t'(bus.done), label_t'(1));
        check("t1_label", bus.label_out, fill(8'hC3));
        check("t1_error", label_t'(bus.error), '0);
        check("t1_busy_clr", label_t'(bus.busy), '0);
        tick();
        check("t1_done_pulse", label_t'(bus.done), '0);
        end_gate();

        // AES finishes before any row; wrong row then the selected row
        do_start(3, 8'h01);
        do_aes(8'h5A);
        check("t2_wait_done", label_t'(bus.done), '0);
        put_row(1, 8'h0F);
        check("t2_row1_done", label_t'(bus.done), '0);
        check("t2_row1_busy", label_t'(bus.busy), label_t'(1));
        put_row(3, 8'hAB);
        check("t2_done", label_t'(bus.done), label_t'(1));
        check("t2_label", bus.label_out, fill(8'hF1));
        check("t2_error", label_t'(bus.error), '0);
        end_gate();

        // Row arrives in the same cycle as aes_done
        do_start(0, 8'h02);
        bus.aes_done    = 1'b1;
        bus.aes_out     = fill(8'h3C);
        bus.ctxt_strobe = 1'b1;
        bus.ctxt_idx    = 2'd0;
        bus.ctxt_in     = fill(8'h96);
        tick();
        bus.aes_done    = 1'b0;
        bus.ctxt_strobe = 1'b0;
        check("t3_done", label_t'(bus.done), label_t'(1));
        check("t3_label", bus.label_out, fill(8'hAA));
        check("t3_busy", label_t'(bus.busy), '0);
        end_gate();

        // Start while busy
        do_start(1, 8'h03);
        do_start(2, 8'h04);
        check("t4_no_restart", label_t'(bus.aes_start), '0);
        check("t4_error", label_t'(bus.error), label_t'(1));
        check("t4_init_kept", bus.aes_state_init, fill(8'h03));
        bus.clear_error = 1'b1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t4_set_wins", label_t'(bus.error), label_t'(1));
        tick();
        bus.clear_error = 1'b0;
        check("t4_cleared", label_t'(bus.error), '0);
        put_row(1, 8'h77);
        do_aes(8'h70);
        check("t4_done", label_t'(bus.done), label_t'(1));
        check("t4_label", bus.label_out, fill(8'h07));
        end_gate();

        // Stale row from previous gate must not be used
        put_row(2, 8'h55);
        end_gate();
        do_start(2, 8'h05);
        do_aes(8'hFF);
        check("t5_stale_done", label_t'(bus.done), '0);
        put_row(2, 8'h0F);
        check("t5_done", label_t'(bus.done), label_t'(1));
        check("t5_label", bus.label_out, fill(8'hF0));

        // Write coinciding with gate_id survives; other rows are cleared
        put_row(0, 8'h12);
        bus.ctxt_strobe    = 1'b1;
        bus.ctxt_idx       = 2'd3;
        bus.ctxt_in        = fill(8'h34);
        bus.gate_id_strobe = 1'b1;
        tick();
        bus.ctxt_strobe    = 1'b0;
        bus.gate_id_strobe = 1'b0;
        do_start(3, 8'h06);
        do_aes(8'h00);
        check("t5_keep_done", label_t'(bus.done), label_t'(1));
        check("t5_keep_label", bus.label_out, fill(8'h34));
        do_start(0, 8'h07);
        do_aes(8'h81);
        check("t5_clr_done", label_t'(bus.done), '0);
        put_row(0, 8'h21);
        check("t5_clr_label", bus.label_out, fill(8'hA0));
        check("t5_no_err", label_t'(bus.error), '0);
        end_gate();
        put_row(0, 8'h01);
        put_row(0, 8'h02);
        check("t5_overwrite_err", label_t'(bus.error), label_t'(1));
        end_gate();

        // Reset in AES_WAIT abandons the gate
        do_start(1, 8'h08);
        check("t6_aes_start", label_t'(bus.aes_start), label_t'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_aes(8'hEE);
        check("t6_done", label_t'(bus.done), '0);
        check("t6_busy", label_t'(bus.busy), '0);
        check("t6_error", label_t'(bus.error), '0);
        check("t6_label", bus.label_out, '0);
        check("t6_state_init", bus.aes_state_init, '0);
        put_row(0, 8'h5C);
        do_start(0, 8'h09);
        do_aes(8'hC5);
        check("t6_next_done", label_t'(bus.done), label_t'(1));
        check("t6_next_label", bus.label_out, fill(8'h99));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
